// File: rtl/mem_pkg.sv
// Shared widths, request kinds and FSM states for the processor memory initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  localparam int ADDR_W     = 8;
  localparam int WORD_W     = 14;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 64;
  // First writable word when write protection is compiled in (WPROT_EN).
  localparam int PROT_LIMIT = 22;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'b00,
    KIND_LOAD  = 2'b01,
    KIND_STORE = 2'b10,
    KIND_RSVD  = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_req_chk.sv
// Legality check of a captured request: address range, reserved kind and, with WPROT_EN, store protection.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on the registered request.
module mem_req_chk
  import mem_pkg::*;
(
  input  kind_e             kind,
  input  logic [ADDR_W-1:0] addr,
  output logic              legal,
  output logic              err
);

  logic range_err;
  logic kind_err;
  logic prot_err;

  // Full-width unsigned compare so addresses like 8'hFF are caught, not aliased.
  assign range_err = (addr >= ADDR_W'(DEPTH));
  assign kind_err  = (kind == KIND_RSVD);

`ifdef WPROT_EN
  // The low region holds the program image and must never be overwritten.
  assign prot_err  = (kind == KIND_STORE) && (addr < ADDR_W'(PROT_LIMIT));
`else
  assign prot_err  = 1'b0;
`endif

  assign err   = range_err | kind_err | prot_err;
  assign legal = ~err;

endmodule

// File: rtl/mem_req_ctrl.sv
// Processor-side initiator for the unified instruction/data memory; fills IR (fetch) or MDR (load), optional WPROT_EN store guard.
// Latency: request accepted at edge N, response valid after edge N+1; at least 3 cycles per request.
// Backpressure: one outstanding request; req_ready low from accept until response is taken; response held until resp_ready.
module mem_req_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_err,
  output logic [WORD_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd
);

  state_e            state;
  kind_e             kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              legal;
  logic              err;

  mem_req_chk u_chk (
    .kind  (kind_q),
    .addr  (addr_q),
    .legal (legal),
    .err   (err)
  );

  // The memory sees the captured request directly; address and data are stable for the whole ACCESS cycle.
  assign mem_adr = addr_q;
  assign mem_wd  = wdata_q;

  // Write enable is a pure decode so an asynchronous reset during ACCESS kills the write immediately.
  assign mem_we  = (state == ST_ACCESS) && (kind_q == KIND_STORE) && legal;

  // Request capture, single-cycle memory access, and response hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      ir         <= '0;
      mdr        <= '0;
      kind_q     <= KIND_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            kind_q    <= kind_e'(req_kind);
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= err;
          resp_data  <= '0;
          if (!err) begin
            case (kind_q)
              KIND_FETCH: begin
                ir        <= mem_rd;
                resp_data <= mem_rd;
              end
              KIND_LOAD: begin
                mdr       <= mem_rd[DATA_W-1:0];
                resp_data <= {{(WORD_W-DATA_W){1'b0}}, mem_rd[DATA_W-1:0]};
              end
              default: resp_data <= '0;
            endcase
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 64-word memory attached.
// Latency: checks response one edge after the access cycle.
// Backpressure: exercises held responses and a pending request while busy.
module tb_mem_req_ctrl;
  import mem_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_kind;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_data;
  logic              resp_err;
  logic [WORD_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [WORD_W-1:0] mem_rd;

  logic [WORD_W-1:0] mem [DEPTH];
  int                we_cnt;
  int                tests;
  int                fails;

  localparam logic [WORD_W-1:0] FETCH_W = 14'b110_1_1_101_010010;

  mem_req_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .ir         (ir),
    .mdr        (mdr),
    .mem_adr    (mem_adr),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read port; addresses beyond the array read as zero.
  assign mem_rd = (mem_adr < ADDR_W'(DEPTH)) ? mem[mem_adr[5:0]] : '0;

  // Synchronous write of the low byte, counting every enabled cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_adr[5:0]] = {{(WORD_W-DATA_W){1'b0}}, mem_wd};
      we_cnt = we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete request/response with the consumer ready immediately.
  task automatic xact(input string tag, input logic [1:0] k, input logic [7:0] a,
                      input logic [7:0] d, input logic exp_we,
                      input logic [13:0] exp_data, input logic exp_err);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, req_ready, 1);
    req_valid = 1'b1;
    req_kind  = k;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_we"}, mem_we, exp_we);
    chk({tag, "_adr"}, mem_adr, a);
    if (exp_we) chk({tag, "_wd"}, mem_wd, d);
    chk({tag, "_early"}, resp_valid, 0);
    @(negedge clk);
    chk({tag, "_rv"}, resp_valid, 1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, resp_err, exp_err);
    chk({tag, "_busy"}, req_ready, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_done"}, resp_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, req_ready, 1);
    chk({tag, "_rv"}, resp_valid, 0);
    chk({tag, "_err"}, resp_err, 0);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_mdr"}, mdr, 0);
    chk({tag, "_adr"}, mem_adr, 0);
    chk({tag, "_wd"}, mem_wd, 0);
    chk({tag, "_we"}, mem_we, 0);
  endtask

  initial begin
    int w0;
    tests      = 0;
    fails      = 0;
    we_cnt     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_kind   = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 14'(i * 3);
    mem[0] = FETCH_W;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Fetch fills IR only.
    xact("fetch0", 2'b00, 8'd0, 8'h00, 1'b0, FETCH_W, 1'b0);
    chk("fetch0_ir", ir, FETCH_W);
    chk("fetch0_mdr", mdr, 0);

    // Store then load back the same word.
    w0 = we_cnt;
    xact("st32", 2'b10, 8'd32, 8'hA5, 1'b1, 14'h0000, 1'b0);
    chk("st32_wecnt", we_cnt - w0, 1);
    xact("ld32", 2'b01, 8'd32, 8'h00, 1'b0, 14'h00A5, 1'b0);
    chk("ld32_mdr", mdr, 8'hA5);
    chk("ld32_ir", ir, FETCH_W);

    // Last valid word: 63*3 = 189.
    xact("ld63", 2'b01, 8'd63, 8'h00, 1'b0, 14'h00BD, 1'b0);
    chk("ld63_mdr", mdr, 8'hBD);

    // Error cases: no write, registers untouched.
    w0 = we_cnt;
    xact("ld64", 2'b01, 8'd64, 8'h00, 1'b0, 14'h0000, 1'b1);
    xact("rsvd", 2'b11, 8'd3, 8'h77, 1'b0, 14'h0000, 1'b1);
    xact("st255", 2'b10, 8'd255, 8'h11, 1'b0, 14'h0000, 1'b1);
    xact("fe200", 2'b00, 8'd200, 8'h00, 1'b0, 14'h0000, 1'b1);
    chk("err_wecnt", we_cnt - w0, 0);
    chk("err_ir", ir, FETCH_W);
    chk("err_mdr", mdr, 8'hBD);

`ifdef WPROT_EN
    xact("st5", 2'b10, 8'd5, 8'h5A, 1'b0, 14'h0000, 1'b1);
    chk("st5_mem", mem[5], 15);
    xact("st22", 2'b10, 8'd22, 8'h5A, 1'b1, 14'h0000, 1'b0);
    chk("st22_mem", mem[22], 14'h005A);
`else
    xact("st5", 2'b10, 8'd5, 8'h5A, 1'b1, 14'h0000, 1'b0);
    chk("st5_mem", mem[5], 14'h005A);
    xact("st22", 2'b10, 8'd22, 8'h5A, 1'b1, 14'h0000, 1'b0);
    chk("st22_mem", mem[22], 14'h005A);
`endif

    // Response held while the consumer stalls; a pending request waits.
    @(negedge clk);
    req_valid = 1'b1;
    req_kind  = 2'b00;
    req_addr  = 8'd0;
    @(negedge clk);
    req_kind  = 2'b01;
    req_addr  = 8'd32;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv", resp_valid, 1);
      chk("hold_data", resp_data, FETCH_W);
      chk("hold_busy", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold_rel_rdy", req_ready, 1);
    chk("hold_rel_rv", resp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pend_adr", mem_adr, 32);
    chk("pend_busy", req_ready, 0);
    @(negedge clk);
    chk("pend_rv", resp_valid, 1);
    chk("pend_data", resp_data, 14'h00A5);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Asynchronous reset during a store's access cycle.
    w0 = we_cnt;
    req_valid = 1'b1;
    req_kind  = 2'b10;
    req_addr  = 8'd40;
    req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    chk("arst_we_pre", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    chk("arst_nowr", mem[40], 120);
    chk("arst_wecnt", we_cnt - w0, 0);
    rst_n = 1'b1;
    xact("ld40", 2'b01, 8'd40, 8'h00, 1'b0, 14'h0078, 1'b0);
    chk("ld40_mdr", mdr, 8'h78);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
